// File: rtl/ftile_ghrd_avst_tx_arb.sv
// ftile_ghrd_avst_tx_arb: round-robin packet arbiter merging NUM_REQ Avalon-ST sources
// onto one TX stream, with oversize-packet truncation and drop.
module ftile_ghrd_avst_tx_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int EMPTY_BITS = 3,
    parameter int NUM_REQ    = 2,
    parameter int MAX_BEATS  = 1200
) (
    input  logic                            i_tx_clk,
    input  logic                            i_tx_rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ-1:0]              i_req_sop,
    input  logic [NUM_REQ-1:0]              i_req_eop,
    input  logic [NUM_REQ-1:0]              i_req_error,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ*EMPTY_BITS-1:0]   i_req_empty,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic                            o_av_st_tx_valid,
    output logic                            o_av_st_tx_startofpacket,
    output logic                            o_av_st_tx_endofpacket,
    output logic                            o_av_st_tx_error,
    output logic [DATA_WIDTH-1:0]           o_av_st_tx_data,
    output logic [EMPTY_BITS-1:0]           o_av_st_tx_empty,
    input  logic                            i_av_st_tx_ready,
    output logic [NUM_REQ-1:0]              o_grant,
    input  logic                            i_clr_err,
    output logic                            o_oversize_err
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d, p_q, p_d, g_sel;
    logic [11:0]     cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [DATA_WIDTH-1:0] data_a [NUM_REQ];
    logic [EMPTY_BITS-1:0] empty_a [NUM_REQ];
    logic [NUM_REQ-1:0]    cand;
    logic [GW:0]     idx;
    logic            found, busy, xfer, force_eop;

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign data_a[n]  = i_req_data[n*DATA_WIDTH +: DATA_WIDTH];
        assign empty_a[n] = i_req_empty[n*EMPTY_BITS +: EMPTY_BITS];
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        cand  = i_req_valid & i_req_sop;
        found = 1'b0;
        g_sel = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, p_q} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
            if (!found && cand[idx[GW-1:0]]) begin
                found = 1'b1;
                g_sel = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        busy      = state_q == BUSY;
        // Next transfer would be the MAX_BEATS-th with no eop from the source: truncate it
        force_eop = busy && cnt_q == 12'(MAX_BEATS - 1) && !i_req_eop[g_q];
        o_av_st_tx_valid         = busy && i_req_valid[g_q];
        o_av_st_tx_startofpacket = busy && i_req_sop[g_q];
        o_av_st_tx_endofpacket   = busy && (i_req_eop[g_q] || force_eop);
        o_av_st_tx_error         = busy && (i_req_error[g_q] || force_eop);
        o_av_st_tx_data          = busy ? data_a[g_q] : '0;
        o_av_st_tx_empty         = busy ? empty_a[g_q] : '0;
        xfer        = o_av_st_tx_valid && i_av_st_tx_ready;
        o_req_ready = '0;
        o_grant     = '0;
        if (state_q != IDLE) begin
            o_req_ready[g_q] = busy ? i_av_st_tx_ready : 1'b1;
            o_grant[g_q]     = 1'b1;
        end
        if (state_q == IDLE && found) begin
            state_d = BUSY;
            g_d     = g_sel;
            cnt_d   = '0;
        end
        if (xfer) begin
            cnt_d = cnt_q + 12'd1;
            if (i_req_eop[g_q]) begin
                state_d = IDLE;
                p_d     = g_q;
                cnt_d   = '0;
            end else if (force_eop) begin
                state_d = DROP;
                cnt_d   = '0;
            end
        end
        if (state_q == DROP && i_req_valid[g_q] && i_req_eop[g_q]) begin
            state_d = IDLE;
            p_d     = g_q;
        end
        err_d = (xfer && force_eop) || (err_q && !i_clr_err);
    end

    always_ff @(posedge i_tx_clk or posedge i_tx_rst) begin
        if (i_tx_rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_oversize_err = err_q;

endmodule

// File: tb/tb_ftile_ghrd_avst_tx_arb.sv
// tb_ftile_ghrd_avst_tx_arb: scenario tasks plus a randomized run against a packet-rule model.
module tb_ftile_ghrd_avst_tx_arb;
    localparam int DW = 16;
    localparam int EB = 2;
    localparam int NR = 2;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [EB-1:0] m;
        logic          s;
        logic          e;
        logic          x;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0] v, s, e, er, rdy, gnt, en;
    logic [NR*DW-1:0] d;
    logic [NR*EB-1:0] em;
    logic ov, os, oe, ox, dsr, clr, flag;
    logic [DW-1:0] od;
    logic [EB-1:0] oem;

    beat_t q0[$], q1[$], pk[$], exp[$], oq[$];
    logic [NR-1:0] gh[$], rh[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ftile_ghrd_avst_tx_arb #(.DATA_WIDTH(DW), .EMPTY_BITS(EB), .NUM_REQ(NR), .MAX_BEATS(MB)) dut (
        .i_tx_clk(clk), .i_tx_rst(rst),
        .i_req_valid(v), .i_req_sop(s), .i_req_eop(e), .i_req_error(er),
        .i_req_data(d), .i_req_empty(em), .o_req_ready(rdy),
        .o_av_st_tx_valid(ov), .o_av_st_tx_startofpacket(os), .o_av_st_tx_endofpacket(oe),
        .o_av_st_tx_error(ox), .o_av_st_tx_data(od), .o_av_st_tx_empty(oem),
        .i_av_st_tx_ready(dsr), .o_grant(gnt), .i_clr_err(clr), .o_oversize_err(flag)
    );

    task automatic drive();
        beat_t b;
        for (int n = 0; n < NR; n++) begin
            b = '0;
            if (n == 0 && q0.size() > 0) b = q0[0];
            if (n == 1 && q1.size() > 0) b = q1[0];
            v[n]  = en[n] && ((n == 0) ? q0.size() > 0 : q1.size() > 0);
            s[n]  = b.s;
            e[n]  = b.e;
            er[n] = b.x;
            d[n*DW +: DW] = b.d;
            em[n*EB +: EB] = b.m;
        end
    endtask

    task automatic push_pkt(input int n, input int len, input bit rnd);
        beat_t b;
        pk.delete();
        for (int i = 0; i < len; i++) begin
            b.d = DW'($urandom);
            b.m = EB'($urandom);
            b.s = (i == 0);
            b.e = (i == len - 1);
            b.x = rnd && ($urandom % 8 == 0);
            pk.push_back(b);
            if (n == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic add_exp();
        foreach (pk[i]) exp.push_back(pk[i]);
    endtask

    task automatic step();
        logic [NR-1:0] acc;
        beat_t ob;
        acc = v & rdy;
        if (ov && dsr) begin
            ob = '{d: od, m: oem, s: os, e: oe, x: ox};
            oq.push_back(ob);
        end
        gh.push_back(gnt);
        rh.push_back(rdy);
        @(posedge clk); #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        drive(); #1;
    endtask

    task automatic start(input logic [NR-1:0] enable);
        en = enable;
        gh.delete(); rh.delete(); oq.delete(); exp.delete();
        drive(); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; dsr = 1'b1; en = '0;
        q0.delete(); q1.delete();
        drive();
        repeat (2) @(posedge clk); #1;
        n_cmp++;
        if ({ov, os, oe, ox, rdy, gnt, flag, od, oem} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {ov, os, oe, ox, rdy, gnt, flag, od, oem});
        end
        push_pkt(1, 1, 0);
        start(2'b11);
        @(posedge clk); #1;
        n_cmp++;
        if ({ov, rdy, gnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold_no_grant: got %b want 0", {ov, rdy, gnt});
        end
        rst = 1'b0; #1;
        step();
        n_cmp++;
        if (gnt !== 2'b10) begin n_bad++; $display("FAIL reset_first_grant: got %b want 10", gnt); end
        step(); step();
        n_cmp++;
        if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_idle_after: got %b want 00", gnt); end
    endtask

    task automatic test_alternate();
        start(2'b00);
        push_pkt(0, 3, 0); add_exp();
        push_pkt(1, 3, 0); add_exp();
        push_pkt(0, 3, 0); add_exp();
        push_pkt(1, 3, 0); add_exp();
        start(2'b11);
        exp.delete();
        foreach (q0[i]) if (i < 3) exp.push_back(q0[i]);
        foreach (q1[i]) if (i < 3) exp.push_back(q1[i]);
        foreach (q0[i]) if (i >= 3) exp.push_back(q0[i]);
        foreach (q1[i]) if (i >= 3) exp.push_back(q1[i]);
        for (int i = 0; i < 16; i++) step();
        for (int i = 0; i < 16; i++) begin
            logic [NR-1:0] w;
            w = (i % 4 == 0) ? 2'b00 : (((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
            n_cmp++;
            if (gh[i] !== w) begin n_bad++; $display("FAIL alt_grant cyc %0d: got %b want %b", i, gh[i], w); end
        end
        n_cmp++;
        if (oq.size() != 12 || oq != exp) begin
            n_bad++;
            $display("FAIL alt_order: got %0d beats want 12 in order R0,R1,R0,R1", oq.size());
        end
    endtask

    task automatic test_nosop();
        beat_t b;
        start(2'b01);
        b = '{d: 16'h1234, m: 2'd1, s: 1'b0, e: 1'b1, x: 1'b0};
        q0.push_back(b);
        drive(); #1;
        repeat (3) step();
        n_cmp++;
        if ({gh[1], gh[2], rh[1], rh[2], ov} !== '0) begin
            n_bad++;
            $display("FAIL nosop_ignored: got %b want 0", {gh[1], gh[2], rh[1], rh[2], ov});
        end
        q0.delete(); drive(); #1;
    endtask

    task automatic test_hold();
        start(2'b01);
        push_pkt(0, 4, 0); add_exp();
        push_pkt(1, 2, 0); add_exp();
        drive(); #1;
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin en = 2'b11; drive(); #1; end
            if (i >= 1 && i <= 4) begin
                n_cmp++;
                if ({rdy, gnt} !== 4'b0101) begin
                    n_bad++;
                    $display("FAIL hold_r1_blocked cyc %0d: got rdy %b gnt %b want 01 01", i, rdy, gnt);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if ({ov, oe, ox} !== 3'b110) begin n_bad++; $display("FAIL hold_maxbeat_eop: got %b want 110", {ov, oe, ox}); end
            end
            if (i == 6) begin
                n_cmp++;
                if (gnt !== 2'b10) begin n_bad++; $display("FAIL hold_next_grant: got %b want 10", gnt); end
            end
            step();
        end
        n_cmp++;
        if (oq != exp || flag !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_data: got %0d beats flag %b want %0d beats flag 0", oq.size(), flag, exp.size());
        end
    endtask

    task automatic test_backpressure();
        start(2'b01);
        push_pkt(0, 4, 1); add_exp();
        drive(); #1;
        for (int i = 0; i < 12; i++) begin
            dsr = (i == 0) ? 1'b1 : 1'(i % 2 == 1);
            #1;
            if (i >= 1 && i <= 7) begin
                n_cmp++;
                if (rdy !== {1'b0, dsr}) begin n_bad++; $display("FAIL bp_ready cyc %0d: got %b want %b", i, rdy, {1'b0, dsr}); end
            end
            step();
        end
        dsr = 1'b1;
        n_cmp++;
        if (oq != exp) begin n_bad++; $display("FAIL bp_beats: got %0d beats want 4 in order", oq.size()); end
    endtask

    task automatic test_oversize();
        bit hit;
        start(2'b10);
        push_pkt(1, 6, 0);
        for (int i = 0; i < 4; i++) exp.push_back(pk[i]);
        exp[3].e = 1'b1;
        exp[3].x = 1'b1;
        drive(); #1;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                n_cmp++;
                if ({ov, oe, ox} !== 3'b111) begin n_bad++; $display("FAIL ovs_forced_beat: got %b want 111", {ov, oe, ox}); end
            end
            if (i == 5 || i == 6) begin
                n_cmp++;
                if ({ov, rdy, gnt} !== 5'b01010) begin
                    n_bad++;
                    $display("FAIL ovs_drop cyc %0d: got %b want 01010", i, {ov, rdy, gnt});
                end
            end
            step();
        end
        n_cmp++;
        if (oq != exp || q1.size() != 0 || flag !== 1'b1) begin
            n_bad++;
            $display("FAIL ovs_result: got %0d beats left %0d flag %b want 4 0 1", oq.size(), q1.size(), flag);
        end
        step(); step();
        n_cmp++;
        if (flag !== 1'b1) begin n_bad++; $display("FAIL ovs_sticky: got %b want 1", flag); end
        clr = 1'b1; step(); clr = 1'b0;
        n_cmp++;
        if (flag !== 1'b0) begin n_bad++; $display("FAIL ovs_clear: got %b want 0", flag); end
        push_pkt(1, 6, 0);
        drive(); #1;
        hit = 0;
        for (int i = 0; i < 9; i++) begin
            clr = ov && ox;
            hit |= clr;
            step();
        end
        clr = 1'b0;
        n_cmp++;
        if (!hit || flag !== 1'b1) begin n_bad++; $display("FAIL ovs_set_wins: got hit %b flag %b want 1 1", hit, flag); end
    endtask

    task automatic test_reset_mid();
        start(2'b01);
        push_pkt(0, 4, 0);
        drive(); #1;
        step(); step();
        n_cmp++;
        if ({ov, os} !== 2'b10) begin n_bad++; $display("FAIL rmid_beat2: got %b want 10", {ov, os}); end
        rst = 1'b1; #1;
        n_cmp++;
        if ({ov, os, oe, ox, rdy, gnt, flag, od, oem} !== '0) begin
            n_bad++;
            $display("FAIL rmid_async: got %h want 0", {ov, os, oe, ox, rdy, gnt, flag, od, oem});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete(); q1.delete();
        push_pkt(0, 2, 0);
        push_pkt(1, 2, 0);
        start(2'b11);
        step();
        n_cmp++;
        if (gnt !== 2'b01) begin n_bad++; $display("FAIL rmid_r0_first: got %b want 01", gnt); end
        repeat (8) step();
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin n_bad++; $display("FAIL rmid_drain: got %0d left want 0", q0.size() + q1.size()); end
    endtask

    task automatic test_random();
        int own, last, cnt;
        bit drop, fl, set, over;
        logic ev;
        logic [NR-1:0] erdy, eg;
        logic [2+DW+EB:0] eb, ab;
        rst = 1'b1; clr = 1'b0; dsr = 1'b1;
        q0.delete(); q1.delete();
        start(2'b00);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        own = -1; last = NR - 1; cnt = 0; drop = 0; fl = 0;
        for (int c = 0; c < 800; c++) begin
            if (q0.size() == 0 && $urandom % 3 == 0) push_pkt(0, 1 + $urandom % 6, 1);
            if (q1.size() == 0 && $urandom % 3 == 0) push_pkt(1, 1 + $urandom % 6, 1);
            en  = {1'($urandom % 4 != 0), 1'($urandom % 4 != 0)};
            dsr = 1'($urandom % 4 != 0);
            clr = 1'($urandom % 16 == 0);
            drive(); #1;
            ev = 0; erdy = '0; eg = '0; eb = '0; over = 0;
            if (own >= 0) begin
                eg[own] = 1'b1;
                if (drop) erdy[own] = 1'b1;
                else begin
                    over = (cnt == MB - 1) && !e[own];
                    erdy[own] = dsr;
                    ev = v[own];
                    eb = {s[own], e[own] | over, er[own] | over, d[own*DW +: DW], em[own*EB +: EB]};
                end
            end
            n_cmp++;
            if ({ov, rdy, gnt, flag} !== {ev, erdy, eg, fl}) begin
                n_bad++;
                $display("FAIL rand_ctrl cyc %0d: got %b want %b", c, {ov, rdy, gnt, flag}, {ev, erdy, eg, fl});
            end
            ab = {os, oe, ox, od, oem};
            if (ev) begin
                n_cmp++;
                if (ab !== eb) begin n_bad++; $display("FAIL rand_beat cyc %0d: got %h want %h", c, ab, eb); end
            end
            set = 0;
            if (own < 0) begin
                for (int k = 1; k <= NR; k++)
                    if (own < 0 && v[(last + k) % NR] && s[(last + k) % NR]) begin
                        own = (last + k) % NR;
                        cnt = 0;
                    end
            end else if (drop) begin
                if (v[own] && e[own]) begin last = own; own = -1; drop = 0; end
            end else if (v[own] && dsr) begin
                if (e[own]) begin last = own; own = -1; cnt = 0; end
                else if (over) begin drop = 1; set = 1; cnt = 0; end
                else cnt++;
            end
            fl = set | (fl & !clr);
            step();
        end
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_alternate();
        test_nosop();
        test_hold();
        test_backpressure();
        test_oversize();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ftile_ghrd_avst_tx_arb.md
FTILE_GHRD_AVST_TX_ARB -- requirements
Module: ftile_ghrd_avst_tx_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, per-beat data width in bits.
REQ-002 SHALL have parameter EMPTY_BITS, default 3, empty-field width.
REQ-003 SHALL have parameter NUM_REQ, default 2, range 2..4, number of requesters.
REQ-004 SHALL have parameter MAX_BEATS, default 1200, maximum beats per packet, range 2..4095.
REQ-005 SHALL have port i_tx_clk, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port i_tx_rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports i_req_valid/i_req_sop/i_req_eop/i_req_error, input, NUM_REQ each, per-requester Avalon-ST controls, bit n = requester n.
REQ-008 SHALL have port i_req_data, input, NUM_REQ*DATA_WIDTH, requester n at slice [n*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port i_req_empty, input, NUM_REQ*EMPTY_BITS, packed as i_req_data.
REQ-010 SHALL have port o_req_ready, output, NUM_REQ, per-requester ready, ready latency 0.
REQ-011 SHALL have ports o_av_st_tx_valid/o_av_st_tx_startofpacket/o_av_st_tx_endofpacket/o_av_st_tx_error, output, 1 each, toward the AXI-ST bridge.
REQ-012 SHALL have ports o_av_st_tx_data (DATA_WIDTH) and o_av_st_tx_empty (EMPTY_BITS), output.
REQ-013 SHALL have port i_av_st_tx_ready, input, 1, downstream ready, ready latency 0.
REQ-014 SHALL have port o_grant, output, NUM_REQ, one-hot registered grant, zero when idle.
REQ-015 SHALL have port i_clr_err, input, 1, clear pulse for o_oversize_err.
REQ-016 SHALL have port o_oversize_err, output, 1, sticky oversize-packet flag.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DROP with registered grant index g and round-robin pointer p (last granted requester).
REQ-018 In IDLE: candidates = requesters with valid&sop; SHALL register grant to the first candidate searching p+1, p+2, ... modulo NUM_REQ, and move to BUSY next cycle; no candidate -> stay IDLE.
REQ-019 In IDLE all o_req_ready SHALL be 0 and o_av_st_tx_valid 0; a requester asserting valid without sop is not a candidate and is not acknowledged.
REQ-020 In BUSY: output data/sop/eop/empty/error SHALL combinationally mux requester g; o_av_st_tx_valid = i_req_valid[g]; o_req_ready[g] = i_av_st_tx_ready; other readies 0.
REQ-021 Beat transfer = o_av_st_tx_valid & i_av_st_tx_ready; grant SHALL hold from SOP to EOP regardless of other requesters.
REQ-022 Transfer with eop in BUSY SHALL return to IDLE, set p = g, clear beat counter; minimum one idle cycle between packets.
REQ-023 Beat counter (12 bit) SHALL count transfers in BUSY, resetting to 0 at every packet end.
REQ-024 On the MAX_BEATS-th transfer without input eop: output SHALL force eop=1 and error=1 on that beat, set o_oversize_err, go to DROP.
REQ-025 In DROP: o_req_ready[g]=1, o_av_st_tx_valid=0; requester g beats discarded until its eop transfer, then IDLE with p = g.
REQ-026 o_oversize_err SHALL clear on i_clr_err; simultaneous set and clear -> set wins.
REQ-027 Output sop/eop/error SHALL pass requester values unmodified except per REQ-024; o_grant reflects g in BUSY and DROP.

Reset
REQ-028 i_tx_rst SHALL asynchronously force IDLE, g=0, p=NUM_REQ-1 (requester 0 highest first), counter 0, o_grant 0, o_oversize_err 0, all o_req_ready 0, o_av_st_tx_valid 0.
REQ-029 Reset mid-packet SHALL abort without generating eop; after release arbitration restarts per REQ-018.

Verification
REQ-030 Both requesters post 3-beat packets continuously, ready=1 -> output order R0,R1,R0,R1; each packet 3 beats + 1 idle cycle; o_grant alternates 01,10.
REQ-031 R0 mid-packet (beat 2 of 5), R1 asserts sop -> R1 o_req_ready stays 0 until R0 eop transfers; R1 granted next arbitration.
REQ-032 Downstream ready toggles 1,0,1,0 during a 4-beat packet -> exactly 4 transfers, data order preserved, no beat duplicated or lost.
REQ-033 MAX_BEATS=4, R1 sends 6-beat packet -> beat 4 output with eop=1,error=1; beats 5-6 consumed with output valid=0; o_oversize_err=1 until i_clr_err; i_clr_err coincident with new overflow keeps it 1.
REQ-034 Assert i_tx_rst during beat 2 of an R0 packet -> all outputs 0 immediately; after release R0 and R1 both with sop -> R0 granted first.
